seg_scan_driver: RTL

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_pkg.sv | 48 ++++
 rtl/seg_glyph_enc.sv | 37 +++
 rtl/seg_scan_driver.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment scan driver: glyph code map,
// code width and active-low segment patterns (bit order g..a).
package seg_pkg;

  localparam int CODE_W = 5;

  typedef logic [CODE_W-1:0] glyph_t;

  // Letter / symbol codes; 0..9 are the decimal digits themselves.
  localparam glyph_t GLYPH_E     = 5'd10;
  localparam glyph_t GLYPH_S     = 5'd11;
  localparam glyph_t GLYPH_O     = 5'd12;
  localparam glyph_t GLYPH_L     = 5'd13;
  localparam glyph_t GLYPH_P     = 5'd14;
  localparam glyph_t GLYPH_A     = 5'd15;
  localparam glyph_t GLYPH_U     = 5'd16;
  localparam glyph_t GLYPH_R     = 5'd17;
  localparam glyph_t GLYPH_N     = 5'd18;
  localparam glyph_t GLYPH_MINUS = 5'd19;
  localparam glyph_t GLYPH_BLANK = 5'd31;

  // Active-low patterns, bit 6 = g ... bit 0 = a.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_S     = 7'h12;
  localparam logic [6:0] SEG_O     = 7'h40;
  localparam logic [6:0] SEG_L     = 7'h47;
  localparam logic [6:0] SEG_P     = 7'h0C;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_U     = 7'h41;
  localparam logic [6:0] SEG_R     = 7'h2F;
  localparam logic [6:0] SEG_N     = 7'h2B;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_OFF   = 7'h7F;

  // Full 8-bit dark pattern including the decimal point.
  localparam logic [7:0] SEG_ALL_OFF = 8'hFF;

endpackage

// File: rtl/seg_glyph_enc.sv
// Combinational glyph code to active-low seven-segment pattern decoder.
module seg_glyph_enc
  import seg_pkg::*;
(
  input  glyph_t     code_i,
  output logic [6:0] seg_n_o
);

  // Look up the segment pattern; every unmapped code shows nothing.
  always_comb begin
    seg_n_o = SEG_OFF;
    case (code_i)
      5'd0:        seg_n_o = SEG_0;
      5'd1:        seg_n_o = SEG_1;
      5'd2:        seg_n_o = SEG_2;
      5'd3:        seg_n_o = SEG_3;
      5'd4:        seg_n_o = SEG_4;
      5'd5:        seg_n_o = SEG_5;
      5'd6:        seg_n_o = SEG_6;
      5'd7:        seg_n_o = SEG_7;
      5'd8:        seg_n_o = SEG_8;
      5'd9:        seg_n_o = SEG_9;
      GLYPH_E:     seg_n_o = SEG_E;
      GLYPH_S:     seg_n_o = SEG_S;
      GLYPH_O:     seg_n_o = SEG_O;
      GLYPH_L:     seg_n_o = SEG_L;
      GLYPH_P:     seg_n_o = SEG_P;
      GLYPH_A:     seg_n_o = SEG_A;
      GLYPH_U:     seg_n_o = SEG_U;
      GLYPH_R:     seg_n_o = SEG_R;
      GLYPH_N:     seg_n_o = SEG_N;
      GLYPH_MINUS: seg_n_o = SEG_MINUS;
      default:     seg_n_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scan driver. Inputs are snapshotted once per
// frame so a frame is always drawn from one consistent set of values;
// segment and anode outputs are registered together to avoid ghosting.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int N_DIGITS     = 8,
  parameter int REFRESH_DIV  = 100_000,
  parameter int BLINK_FRAMES = 250
) (
  input  logic                         Clk,
  input  logic                         Rst_n,
  input  logic [CODE_W*N_DIGITS-1:0]   glyph_codes,
  input  logic [N_DIGITS-1:0]          digit_en,
  input  logic [N_DIGITS-1:0]          dp_mask,
  input  logic [N_DIGITS-1:0]          blink_mask,
  input  logic                         lzs_en,
  output logic [7:0]                   seg_n,
  output logic [N_DIGITS-1:0]          anode_n,
  output logic                         frame_start
);

  localparam int SLOT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W  = $clog2(N_DIGITS);
  localparam int FRM_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_DIGITS - 1);
  localparam logic [FRM_W-1:0]  FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);

  logic [SLOT_W-1:0]   slot_cnt_q, slot_cnt_d;
  logic [IDX_W-1:0]    digit_idx_q, digit_idx_d;
  logic [FRM_W-1:0]    frame_cnt_q, frame_cnt_d;
  logic                blink_phase_q, blink_phase_d;
  logic                frame_start_q;
  logic                tick, wrap;

  glyph_t              sh_code_q [N_DIGITS];
  logic [N_DIGITS-1:0] sh_en_q, sh_dp_q, sh_blink_q;
  logic                sh_lzs_q;

  logic [N_DIGITS-1:0] lz_sup;
  logic                lz_run;
  glyph_t              cur_code;
  logic [6:0]          glyph_seg;
  logic [7:0]          seg_q, seg_d;
  logic [N_DIGITS-1:0] anode_q, anode_d;

  assign tick = (slot_cnt_q == SLOT_LAST);
  assign wrap = tick && (digit_idx_q == IDX_LAST);

  // Slot timer, digit pointer and blink frame counter next-state.
  always_comb begin
    slot_cnt_d    = tick ? '0 : slot_cnt_q + 1'b1;
    digit_idx_d   = digit_idx_q;
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if (tick) begin
      digit_idx_d = wrap ? '0 : digit_idx_q + 1'b1;
    end
    if (wrap) begin
      if (frame_cnt_q == FRM_LAST) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d   = frame_cnt_q + 1'b1;
      end
    end
  end

  // Scan state registers; reset restarts a full-length slot 0.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      slot_cnt_q    <= '0;
      digit_idx_q   <= '0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      slot_cnt_q    <= slot_cnt_d;
      digit_idx_q   <= digit_idx_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      frame_start_q <= wrap;
    end
  end

  // Snapshot all display inputs on the tick that starts a new frame.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      for (int i = 0; i < N_DIGITS; i++) sh_code_q[i] <= GLYPH_BLANK;
      sh_en_q    <= '0;
      sh_dp_q    <= '0;
      sh_blink_q <= '0;
      sh_lzs_q   <= 1'b0;
    end else if (wrap) begin
      for (int i = 0; i < N_DIGITS; i++) sh_code_q[i] <= glyph_codes[i*CODE_W +: CODE_W];
      sh_en_q    <= digit_en;
      sh_dp_q    <= dp_mask;
      sh_blink_q <= blink_mask;
      sh_lzs_q   <= lzs_en;
    end
  end

  // Leading zeros: walk down from the top digit, ignoring disabled digits,
  // until the first enabled non-zero code; digit 0 is always shown.
  always_comb begin
    lz_run = 1'b1;
    lz_sup = '0;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      if (sh_en_q[i]) begin
        if (lz_run && (sh_code_q[i] == '0)) begin
          lz_sup[i] = 1'b1;
        end else begin
          lz_run = 1'b0;
        end
      end
    end
  end

  assign cur_code = sh_code_q[digit_idx_q];

  seg_glyph_enc u_glyph_enc (
    .code_i  (cur_code),
    .seg_n_o (glyph_seg)
  );

  // Output pattern for the digit currently addressed by the scan.
  always_comb begin
    seg_d   = SEG_ALL_OFF;
    anode_d = '1;
    if (sh_en_q[digit_idx_q]) begin
      anode_d = ~({{(N_DIGITS-1){1'b0}}, 1'b1} << digit_idx_q);
      if (!(sh_blink_q[digit_idx_q] && blink_phase_q)) begin
        seg_d[7]   = ~sh_dp_q[digit_idx_q];
        seg_d[6:0] = (sh_lzs_q && lz_sup[digit_idx_q]) ? SEG_OFF : glyph_seg;
      end
    end
  end

  // Segment and anode drive registered in the same cycle.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      seg_q   <= SEG_ALL_OFF;
      anode_q <= '1;
    end else begin
      seg_q   <= seg_d;
      anode_q <= anode_d;
    end
  end

  assign seg_n       = seg_q;
  assign anode_n     = anode_q;
  assign frame_start = frame_start_q;

endmodule
